// File: rtl/secuenciador_hamming.sv
// Sequencer for the Hamming (8,4) SECDED datapath: captures the switches, waits for the
// datapath to settle, classifies the result and holds it on the LEDs for a display window.
module secuenciador_hamming #(
  parameter int unsigned LATENCIA       = 2,
  parameter int unsigned TIEMPO_MOSTRAR = 27_000_000,
  parameter int unsigned ANCHO_CUENTA   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iniciar,
  input  logic [3:0]              conmutador_4,
  input  logic [7:0]              conmutador_8,
  output logic [3:0]              dp_conmutador_4,
  output logic [7:0]              dp_conmutador_8,
  input  logic [3:0]              dp_pos_error,
  input  logic [4:0]              dp_w_corregida_b4,
  output logic [4:0]              led,
  output logic                    ocupado,
  output logic                    listo,
  output logic                    error_simple,
  output logic                    error_doble,
  output logic [ANCHO_CUENTA-1:0] cuenta_simple,
  output logic [ANCHO_CUENTA-1:0] cuenta_doble
);

  localparam int unsigned MAX_T   = (TIEMPO_MOSTRAR > LATENCIA) ? TIEMPO_MOSTRAR : LATENCIA;
  localparam int unsigned ANCHO_T = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [ANCHO_T-1:0] CARGA_LAT = ANCHO_T'(LATENCIA - 1);
  localparam logic [ANCHO_T-1:0] CARGA_MOS = ANCHO_T'(TIEMPO_MOSTRAR - 1);

  localparam logic [2:0] ESPERA  = 3'd0;
  localparam logic [2:0] CAPTURA = 3'd1;
  localparam logic [2:0] ASENTAR = 3'd2;
  localparam logic [2:0] EVALUAR = 3'd3;
  localparam logic [2:0] MOSTRAR = 3'd4;

  logic [2:0]              estado_q, estado_d;
  logic [ANCHO_T-1:0]      cnt_q, cnt_d;
  logic                    iniciar_q;
  logic                    inicio;
  logic                    paridad_q, paridad_d;
  logic [3:0]              pos_q, pos_d;
  logic [4:0]              w_q, w_d;
  logic [3:0]              dp4_q, dp4_d;
  logic [7:0]              dp8_q, dp8_d;
  logic [4:0]              led_q, led_d;
  logic                    ocupado_q, ocupado_d;
  logic                    listo_q, listo_d;
  logic                    es_q, es_d;
  logic                    ed_q, ed_d;
  logic [ANCHO_CUENTA-1:0] cs_q, cs_d;
  logic [ANCHO_CUENTA-1:0] cd_q, cd_d;

  assign inicio = iniciar & ~iniciar_q;

  // Datapath outputs are sampled on leaving ASENTAR, exactly LATENCIA cycles after dp_* change.
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    paridad_d = paridad_q;
    pos_d     = pos_q;
    w_d       = w_q;
    dp4_d     = dp4_q;
    dp8_d     = dp8_q;
    led_d     = led_q;
    es_d      = es_q;
    ed_d      = ed_q;
    cs_d      = cs_q;
    cd_d      = cd_q;
    case (estado_q)
      ESPERA: begin
        if (inicio) estado_d = CAPTURA;
      end
      CAPTURA: begin
        dp4_d     = conmutador_4;
        dp8_d     = conmutador_8;
        paridad_d = ^conmutador_8;
        cnt_d     = CARGA_LAT;
        estado_d  = ASENTAR;
      end
      ASENTAR: begin
        if (cnt_q == '0) begin
          pos_d    = dp_pos_error;
          w_d      = dp_w_corregida_b4;
          estado_d = EVALUAR;
        end else begin
          cnt_d = cnt_q - ANCHO_T'(1);
        end
      end
      EVALUAR: begin
        if ((pos_q != 4'd0) && !paridad_q) begin
          led_d = 5'b11111;
          es_d  = 1'b0;
          ed_d  = 1'b1;
          if (cd_q != '1) cd_d = cd_q + ANCHO_CUENTA'(1);
        end else begin
          // Odd parity means one flipped bit (possibly the global parity bit): data is valid.
          led_d = w_q;
          es_d  = paridad_q;
          ed_d  = 1'b0;
          if (paridad_q && (cs_q != '1)) cs_d = cs_q + ANCHO_CUENTA'(1);
        end
        cnt_d    = CARGA_MOS;
        estado_d = MOSTRAR;
      end
      MOSTRAR: begin
        if (cnt_q == '0) estado_d = ESPERA;
        else             cnt_d    = cnt_q - ANCHO_T'(1);
      end
      default: estado_d = ESPERA;
    endcase
    ocupado_d = (estado_d != ESPERA);
    listo_d   = (estado_q == EVALUAR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q  <= ESPERA;
      cnt_q     <= '0;
      iniciar_q <= 1'b0;
      paridad_q <= 1'b0;
      pos_q     <= '0;
      w_q       <= '0;
      dp4_q     <= '0;
      dp8_q     <= '0;
      led_q     <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      es_q      <= 1'b0;
      ed_q      <= 1'b0;
      cs_q      <= '0;
      cd_q      <= '0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      iniciar_q <= iniciar;
      paridad_q <= paridad_d;
      pos_q     <= pos_d;
      w_q       <= w_d;
      dp4_q     <= dp4_d;
      dp8_q     <= dp8_d;
      led_q     <= led_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
      es_q      <= es_d;
      ed_q      <= ed_d;
      cs_q      <= cs_d;
      cd_q      <= cd_d;
    end
  end

  assign dp_conmutador_4 = dp4_q;
  assign dp_conmutador_8 = dp8_q;
  assign led             = led_q;
  assign ocupado         = ocupado_q;
  assign listo           = listo_q;
  assign error_simple    = es_q;
  assign error_doble     = ed_q;
  assign cuenta_simple   = cs_q;
  assign cuenta_doble    = cd_q;

endmodule

// File: tb/tb_secuenciador_hamming.sv
// Directed bench for secuenciador_hamming with a stub datapath keyed on the driven codeword.
module tb_secuenciador_hamming;

  localparam int unsigned ANCHO_CUENTA = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    iniciar;
  logic [3:0]              conmutador_4;
  logic [7:0]              conmutador_8;
  logic [3:0]              dp_conmutador_4;
  logic [7:0]              dp_conmutador_8;
  logic [3:0]              dp_pos_error;
  logic [4:0]              dp_w_corregida_b4;
  logic [4:0]              led;
  logic                    ocupado;
  logic                    listo;
  logic                    error_simple;
  logic                    error_doble;
  logic [ANCHO_CUENTA-1:0] cuenta_simple;
  logic [ANCHO_CUENTA-1:0] cuenta_doble;

  int checks = 0;
  int errors = 0;
  int exp_cs = 0;
  int exp_cd = 0;

  secuenciador_hamming #(
    .LATENCIA      (2),
    .TIEMPO_MOSTRAR(4),
    .ANCHO_CUENTA  (ANCHO_CUENTA)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .iniciar          (iniciar),
    .conmutador_4     (conmutador_4),
    .conmutador_8     (conmutador_8),
    .dp_conmutador_4  (dp_conmutador_4),
    .dp_conmutador_8  (dp_conmutador_8),
    .dp_pos_error     (dp_pos_error),
    .dp_w_corregida_b4(dp_w_corregida_b4),
    .led              (led),
    .ocupado          (ocupado),
    .listo            (listo),
    .error_simple     (error_simple),
    .error_doble      (error_doble),
    .cuenta_simple    (cuenta_simple),
    .cuenta_doble     (cuenta_doble)
  );

  always #5 clk = ~clk;

  // Stub datapath: fixed answers for the codewords used below
  always_comb begin
    case (dp_conmutador_8)
      8'h00:   begin dp_pos_error = 4'd0; dp_w_corregida_b4 = 5'b00110; end
      8'h01:   begin dp_pos_error = 4'd1; dp_w_corregida_b4 = 5'b01010; end
      8'h03:   begin dp_pos_error = 4'd3; dp_w_corregida_b4 = 5'b00000; end
      default: begin dp_pos_error = 4'd0; dp_w_corregida_b4 = {1'b0, dp_conmutador_4}; end
    endcase
  end

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic todo_cero(input string tag);
    comprobar({tag, " dp4"}, 32'(dp_conmutador_4), 32'd0);
    comprobar({tag, " dp8"}, 32'(dp_conmutador_8), 32'd0);
    comprobar({tag, " led"}, 32'(led), 32'd0);
    comprobar({tag, " ocupado"}, 32'(ocupado), 32'd0);
    comprobar({tag, " listo"}, 32'(listo), 32'd0);
    comprobar({tag, " esimple"}, 32'(error_simple), 32'd0);
    comprobar({tag, " edoble"}, 32'(error_doble), 32'd0);
    comprobar({tag, " cs"}, 32'(cuenta_simple), 32'd0);
    comprobar({tag, " cd"}, 32'(cuenta_doble), 32'd0);
  endtask

  function automatic int sat(input int v);
    return (v < 3) ? v + 1 : 3;
  endfunction

  task automatic run_tx(input string tag, input logic [3:0] c4, input logic [7:0] c8,
                        input logic [4:0] e_led, input logic e_s, input logic e_d,
                        input bit molestar);
    int espera;
    conmutador_4 = c4;
    conmutador_8 = c8;
    iniciar      = 1'b1;
    @(negedge clk);
    comprobar({tag, " ocupado_sube"}, 32'(ocupado), 32'd1);
    iniciar = 1'b0;
    espera  = 0;
    while (!listo && espera < 20) begin
      @(negedge clk);
      espera++;
      if (molestar && espera == 1) begin
        iniciar      = 1'b1;
        conmutador_4 = ~c4;
        conmutador_8 = ~c8;
      end
      if (molestar && espera == 2) iniciar = 1'b0;
    end
    if (e_s) exp_cs = sat(exp_cs);
    if (e_d) exp_cd = sat(exp_cd);
    comprobar({tag, " latencia_listo"}, 32'(espera), 32'd4);
    comprobar({tag, " led"}, 32'(led), 32'(e_led));
    comprobar({tag, " esimple"}, 32'(error_simple), 32'(e_s));
    comprobar({tag, " edoble"}, 32'(error_doble), 32'(e_d));
    comprobar({tag, " cs"}, 32'(cuenta_simple), 32'(exp_cs));
    comprobar({tag, " cd"}, 32'(cuenta_doble), 32'(exp_cd));
    comprobar({tag, " dp4"}, 32'(dp_conmutador_4), 32'(c4));
    comprobar({tag, " dp8"}, 32'(dp_conmutador_8), 32'(c8));
    if (molestar) iniciar = 1'b1;
    @(negedge clk);
    comprobar({tag, " listo_pulso"}, 32'(listo), 32'd0);
    iniciar = 1'b0;
    espera  = 0;
    while (ocupado && espera < 20) begin
      @(negedge clk);
      espera++;
    end
    comprobar({tag, " ocupado_baja"}, 32'(espera), 32'd3);
    @(negedge clk);
    comprobar({tag, " sin_reinicio"}, 32'(ocupado), 32'd0);
    comprobar({tag, " led_mantiene"}, 32'(led), 32'(e_led));
    comprobar({tag, " cs_mantiene"}, 32'(cuenta_simple), 32'(exp_cs));
  endtask

  initial begin
    int espera;
    rst_n        = 1'b0;
    iniciar      = 1'b0;
    conmutador_4 = 4'h0;
    conmutador_8 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    todo_cero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      conmutador_4 = 4'(i + 9);
      conmutador_8 = 8'(8'h5A ^ i);
      @(negedge clk);
    end
    todo_cero("reposo");

    run_tx("sin_error", 4'h3, 8'h00, 5'b00110, 1'b0, 1'b0, 1'b0);
    run_tx("simple",    4'h2, 8'h01, 5'b01010, 1'b1, 1'b0, 1'b0);
    run_tx("doble",     4'h1, 8'h03, 5'b11111, 1'b0, 1'b1, 1'b0);
    run_tx("paridad",   4'h5, 8'h80, 5'b00101, 1'b1, 1'b0, 1'b0);
    run_tx("robusto",   4'h2, 8'h01, 5'b01010, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of the display window
    conmutador_4 = 4'h0;
    conmutador_8 = 8'h03;
    iniciar      = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    espera  = 0;
    while (!listo && espera < 20) begin
      @(negedge clk);
      espera++;
    end
    comprobar("rst_mostrar listo", 32'(listo), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    todo_cero("rst_mostrar");
    rst_n  = 1'b1;
    exp_cs = 0;
    exp_cd = 0;
    @(negedge clk);
    comprobar("rst_mostrar espera", 32'(ocupado), 32'd0);

    for (int i = 0; i < 5; i++)
      run_tx($sformatf("saturacion%0d", i), 4'h7, 8'h01, 5'b01010, 1'b1, 1'b0, 1'b0);
    comprobar("saturacion final", 32'(cuenta_simple), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
